// File: rtl/ram_io_responder.sv
// ram_io_responder: memory-side responder for the CPU byte bus.
// Serves a byte RAM (mem_a[17]==0), a small I/O window (mem_a[17:16]==2'b11)
// with an rx input FIFO, a tx output FIFO, a free-running cycle counter with
// byte-wise snapshot readout, and a sticky program_done flag.
// Ports:
//   clk_in, rst_in      - clock, async active-low reset
//   mem_a/mem_dout/mem_wr - CPU address, write data, write strobe
//   mem_din             - registered read data (one cycle after address)
//   rdy_o               - CPU ready, low while the tx FIFO is full
//   rx_data/rx_valid/rx_ready - byte stream from host into the input FIFO
//   tx_data/tx_valid/tx_ready - byte stream from the output FIFO to host
//   program_done        - sticky stop flag
module ram_io_responder #(
  parameter int unsigned RAM_AW    = 17,
  parameter int unsigned IN_DEPTH  = 8,
  parameter int unsigned OUT_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        rdy_o,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        program_done
);

  localparam int unsigned IN_AW  = $clog2(IN_DEPTH);
  localparam int unsigned IN_CW  = IN_AW + 1;
  localparam int unsigned OUT_AW = $clog2(OUT_DEPTH);
  localparam int unsigned OUT_CW = OUT_AW + 1;

  // Storage
  logic [7:0] ram     [0:(1<<RAM_AW)-1];
  logic [7:0] in_mem  [0:IN_DEPTH-1];
  logic [7:0] out_mem [0:OUT_DEPTH-1];

  // FIFO state
  logic [IN_AW-1:0]  in_rd, in_wr;
  logic [IN_CW-1:0]  in_cnt;
  logic [OUT_AW-1:0] out_rd, out_wr;
  logic [OUT_CW-1:0] out_cnt;
  logic              in_empty, in_full, out_empty, out_full;

  logic [31:0] cnt;
  logic [31:0] snap;

  // Address decode
  logic              ram_sel, io_sel;
  logic [2:0]        io_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              unused_addr;

  assign ram_sel     = ~mem_a[17];
  assign io_sel      = (mem_a[17:16] == 2'b11);
  assign io_off      = mem_a[2:0];
  assign ram_idx     = mem_a[RAM_AW-1:0];
  assign unused_addr = ^mem_a[31:18];

  assign in_empty  = (in_cnt == '0);
  assign in_full   = (in_cnt == IN_CW'(IN_DEPTH));
  assign out_empty = (out_cnt == '0);
  assign out_full  = (out_cnt == OUT_CW'(OUT_DEPTH));

  assign rx_ready = ~in_full;
  assign tx_valid = ~out_empty;
  assign tx_data  = out_empty ? 8'h00 : out_mem[out_rd];
  assign rdy_o    = ~out_full;

  // Side-effecting strobes; all CPU-side ones require an accepted edge
  logic in_push, in_pop, out_push, out_pop, ram_we, snap_ld, done_set;
  logic [7:0] out_wdata;

  assign in_push   = rx_valid & ~in_full;
  assign in_pop    = rdy_o & ~mem_wr & io_sel & (io_off == 3'd0) & ~in_empty;
  assign snap_ld   = rdy_o & ~mem_wr & io_sel & (io_off == 3'd4);
  assign done_set  = rdy_o & mem_wr & io_sel & (io_off == 3'd4);
  assign out_push  = rdy_o & mem_wr & io_sel &
                     (((io_off == 3'd0) & (mem_dout != 8'h00)) | (io_off == 3'd4));
  assign out_wdata = (io_off == 3'd4) ? 8'h00 : mem_dout;
  assign out_pop   = ~out_empty & tx_ready;
  assign ram_we    = rdy_o & mem_wr & ram_sel;

  // Read mux; evaluated regardless of rdy_o (only side effects are gated)
  logic [7:0] rd_data;
  always_comb begin
    rd_data = 8'h00;
    if (ram_sel) begin
      rd_data = ram[ram_idx];
    end else if (io_sel) begin
      case (io_off)
        3'd0:    rd_data = in_empty ? 8'h00 : in_mem[in_rd];
        3'd4:    rd_data = cnt[7:0];
        3'd5:    rd_data = snap[15:8];
        3'd6:    rd_data = snap[23:16];
        3'd7:    rd_data = snap[31:24];
        default: rd_data = 8'h00;
      endcase
    end
  end

  // Unreset storage arrays
  always_ff @(posedge clk_in) begin
    if (ram_we)   ram[ram_idx]    <= mem_dout;
    if (in_push)  in_mem[in_wr]   <= rx_data;
    if (out_push) out_mem[out_wr] <= out_wdata;
  end

  // Control state, read data, counter and status
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_din      <= 8'h00;
      cnt          <= 32'h0;
      snap         <= 32'h0;
      program_done <= 1'b0;
      in_rd        <= '0;
      in_wr        <= '0;
      in_cnt       <= '0;
      out_rd       <= '0;
      out_wr       <= '0;
      out_cnt      <= '0;
    end else begin
      cnt <= cnt + 32'd1;
      if (!mem_wr) mem_din <= rd_data;
      if (snap_ld) snap <= cnt;
      if (done_set) program_done <= 1'b1;

      if (in_push) in_wr <= in_wr + IN_AW'(1);
      if (in_pop)  in_rd <= in_rd + IN_AW'(1);
      in_cnt <= in_cnt + IN_CW'(in_push) - IN_CW'(in_pop);

      if (out_push) out_wr <= out_wr + OUT_AW'(1);
      if (out_pop)  out_rd <= out_rd + OUT_AW'(1);
      out_cnt <= out_cnt + OUT_CW'(out_push) - OUT_CW'(out_pop);
    end
  end

endmodule
